// File: rtl/pipe_csel_adder_pkg.sv
// Shared definitions for the pipelined carry-select adder.
// The mode encoding is shared by the adder and anything that drives its sub input.
package pipe_csel_adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/seg_csel_adder.sv
// One carry-select segment: both carry-in sums are formed up front, and the
// late-arriving carry only drives the final select.
module seg_csel_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb_in
);

  logic [W:0] sum0;
  logic [W:0] sum1;

  assign sum0 = {1'b0, a} + {1'b0, b};
  assign sum1 = {1'b0, a} + {1'b0, b} + (W+1)'(1);

  assign s        = cin ? sum1[W-1:0] : sum0[W-1:0];
  assign cout     = cin ? sum1[W]     : sum0[W];
  // Carry into the top bit falls out of the sum bit and the two operand bits.
  assign c_msb_in = a[W-1] ^ b[W-1] ^ s[W-1];

endmodule

// File: rtl/pipe_csel_adder.sv
// Pipelined carry-select adder/subtractor: one segment per stage, operands and
// partial results skewed through the stages, with a global hold on output stall.
module pipe_csel_adder
  import pipe_csel_adder_pkg::*;
#(
  parameter int N    = 32,
  parameter int SEGS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         ovf
);

  localparam int SEG_W = N / SEGS;

  typedef struct packed {
    logic         valid;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] s;
    logic         carry;
    logic         cmsb;
  } stage_t;

  stage_t stage_q [SEGS];
  stage_t stage_d [SEGS];
  logic   advance;

  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  for (genvar k = 0; k < SEGS; k++) begin : g_stage
    logic         src_v;
    logic [N-1:0] src_a;
    logic [N-1:0] src_b;
    logic [N-1:0] src_s;
    logic         src_c;
    logic [SEG_W-1:0] seg_s;
    logic         seg_c;
    logic         seg_cm;
    logic [N-1:0] merged_s;

    if (k == 0) begin : g_first
      // Subtraction becomes A + ~B + 1 here, so later stages never see the mode.
      assign src_v = in_valid && in_ready;
      assign src_a = a;
      assign src_b = (sub == MODE_ADD) ? b : ~b;
      assign src_s = '0;
      assign src_c = (sub == MODE_SUB) ? 1'b1 : cin;
    end else begin : g_next
      assign src_v = stage_q[k-1].valid;
      assign src_a = stage_q[k-1].a;
      assign src_b = stage_q[k-1].b;
      assign src_s = stage_q[k-1].s;
      assign src_c = stage_q[k-1].carry;
    end

    seg_csel_adder #(.W(SEG_W)) u_seg (
      .a        (src_a[k*SEG_W +: SEG_W]),
      .b        (src_b[k*SEG_W +: SEG_W]),
      .cin      (src_c),
      .s        (seg_s),
      .cout     (seg_c),
      .c_msb_in (seg_cm)
    );

    always_comb begin
      merged_s = src_s;
      merged_s[k*SEG_W +: SEG_W] = seg_s;
    end

    assign stage_d[k] = '{valid: src_v, a: src_a, b: src_b, s: merged_s,
                          carry: seg_c, cmsb: seg_cm};
  end

  // Every stage moves together; a stalled output freezes the whole pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SEGS; i++) stage_q[i] <= '0;
    end else if (advance) begin
      for (int i = 0; i < SEGS; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign out_valid = stage_q[SEGS-1].valid;
  assign s         = stage_q[SEGS-1].s;
  assign cout      = stage_q[SEGS-1].carry;
  assign ovf       = stage_q[SEGS-1].cmsb ^ stage_q[SEGS-1].carry;

endmodule

// File: tb/tb_pipe_csel_adder.sv
// Self-checking bench for pipe_csel_adder: directed corner vectors plus random
// traffic scored against an arithmetic reference model.
module tb_pipe_csel_adder;

  localparam int N    = 32;
  localparam int SEGS = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] s;
  logic         cout;
  logic         ovf;

  int checks   = 0;
  int failures = 0;

  // Expected results in acceptance order, packed as {ovf, cout, s}.
  logic [N+1:0] exp_q[$];

  pipe_csel_adder #(.N(N), .SEGS(SEGS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic; overflow means the exact signed
  // result does not fit in N bits, cout in sub mode means no borrow.
  function automatic logic [N+1:0] model(input logic [N-1:0] oa, input logic [N-1:0] ob,
                                         input logic osub, input logic ocin);
    longint       sa;
    longint       sb;
    longint       exact;
    logic [63:0]  ufull;
    logic [N-1:0] rs;
    logic         rc;
    logic         ro;
    sa = longint'($signed(oa));
    sb = longint'($signed(ob));
    if (osub) begin
      exact = sa - sb;
      rs    = oa - ob;
      rc    = (oa >= ob);
    end else begin
      exact = sa + sb + longint'(ocin);
      ufull = 64'(oa) + 64'(ob) + 64'(ocin);
      rs    = ufull[N-1:0];
      rc    = ufull[N];
    end
    ro = (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
    return {ro, rc, rs};
  endfunction

  function automatic logic [N-1:0] rand_operand();
    logic [N-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      2:       v = 32'h7FFF_FFFF;
      3:       v = 32'h8000_0000;
      4:       v = 32'h0000_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic drive_idle();
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    sub      = 1'b0;
    cin      = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    out_ready = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid);
    end
    checks++;
    if (s !== '0) begin
      failures++;
      $display("[TB] FAIL reset_s got=%h want=0", s);
    end
    checks++;
    if ({cout, ovf} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_flags got cout=%b ovf=%b want 0 0", cout, ovf);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [N-1:0] va  [6] = '{32'd432, 32'hFFFF_FFFF, 32'd5, 32'd7, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [N-1:0] vb  [6] = '{32'd5345, 32'd1, 32'd7, 32'd5, 32'd1, 32'd1};
    logic         vsb [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [N-1:0] ws  [6] = '{32'd5777, 32'h0, 32'hFFFF_FFFE, 32'd2, 32'h8000_0000, 32'h7FFF_FFFF};
    logic         wc  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic         wo  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int lat;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      a         = va[i];
      b         = vb[i];
      sub       = vsb[i];
      cin       = 1'b0;
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL dir%0d_in_ready got=%b want=1", i, in_ready);
      end
      @(negedge clk);
      drive_idle();
      lat = 1;
      #1;
      while (out_valid !== 1'b1 && lat < 12) begin
        @(negedge clk);
        #1;
        lat++;
      end
      checks++;
      if (lat != SEGS) begin
        failures++;
        $display("[TB] FAIL dir%0d_latency got=%0d want=%0d", i, lat, SEGS);
      end
      checks++;
      if ({ovf, cout, s} !== {wo[i], wc[i], ws[i]}) begin
        failures++;
        $display("[TB] FAIL dir%0d_result got s=%h cout=%b ovf=%b want s=%h cout=%b ovf=%b",
                 i, s, cout, ovf, ws[i], wc[i], wo[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int           sent = 0;
    int           got = 0;
    int           stall_left = 3;
    bit           stall_started = 1'b0;
    bit           prev_stall = 1'b0;
    logic [N+1:0] prev_out = '0;
    logic [N+1:0] exp;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      @(negedge clk);
      if (sent < 6) begin
        in_valid = 1'b1;
        a        = rand_operand();
        b        = rand_operand();
        sub      = 1'($urandom_range(0, 1));
        cin      = 1'($urandom_range(0, 1));
      end else begin
        drive_idle();
      end
      if (out_valid === 1'b1) stall_started = 1'b1;
      out_ready = (stall_started && stall_left > 0) ? 1'b0 : 1'b1;
      if (!out_ready) stall_left--;
      #1;
      if (!out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("[TB] FAIL b2b_in_ready_stall got=%b want=0", in_ready);
        end
      end
      if (prev_stall) begin
        checks++;
        if ({ovf, cout, s} !== prev_out || out_valid !== 1'b1) begin
          failures++;
          $display("[TB] FAIL b2b_hold got=%h valid=%b want=%h valid=1", {ovf, cout, s}, out_valid, prev_out);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL b2b_unexpected got=%h want=none", {ovf, cout, s});
        end else begin
          exp = exp_q.pop_front();
          if ({ovf, cout, s} !== exp) begin
            failures++;
            $display("[TB] FAIL b2b_result%0d got=%h want=%h", got, {ovf, cout, s}, exp);
          end
        end
        got++;
      end
      if (in_valid && in_ready === 1'b1) begin
        exp_q.push_back(model(a, b, sub, cin));
        sent++;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_out   = {ovf, cout, s};
    end
    checks++;
    if (got != 6 || stall_left != 0) begin
      failures++;
      $display("[TB] FAIL b2b_count got=%0d results stalls_left=%0d want=6 results stalls_left=0", got, stall_left);
    end
    drive_idle();
  endtask

  task automatic test_random();
    bit           prev_stall = 1'b0;
    logic [N+1:0] prev_out = '0;
    logic [N+1:0] exp;
    int           got = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (cyc < 360 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        a        = rand_operand();
        b        = rand_operand();
        sub      = 1'($urandom_range(0, 1));
        cin      = 1'($urandom_range(0, 1));
      end else begin
        drive_idle();
      end
      out_ready = (cyc >= 360) ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        failures++;
        $display("[TB] FAIL rnd_in_ready got=%b want=%b", in_ready, !(out_valid && !out_ready));
      end
      if (prev_stall) begin
        checks++;
        if ({ovf, cout, s} !== prev_out || out_valid !== 1'b1) begin
          failures++;
          $display("[TB] FAIL rnd_hold got=%h want=%h", {ovf, cout, s}, prev_out);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL rnd_unexpected got=%h want=none", {ovf, cout, s});
        end else begin
          exp = exp_q.pop_front();
          if ({ovf, cout, s} !== exp) begin
            failures++;
            $display("[TB] FAIL rnd_result%0d got=%h want=%h", got, {ovf, cout, s}, exp);
          end
        end
        got++;
      end
      if (in_valid && in_ready === 1'b1) exp_q.push_back(model(a, b, sub, cin));
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_out   = {ovf, cout, s};
    end
    checks++;
    if (exp_q.size() != 0 || got == 0) begin
      failures++;
      $display("[TB] FAIL rnd_drain got=%0d pending (%0d delivered) want=0 pending", exp_q.size(), got);
    end
    exp_q.delete();
    drive_idle();
  endtask

  task automatic test_reset_midflight();
    bit stale_seen = 1'b0;
    @(negedge clk);
    in_valid  = 1'b1;
    a         = 32'd100;
    b         = 32'd23;
    sub       = 1'b0;
    cin       = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrst_out_valid got=%b want=0", out_valid);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (out_valid !== 1'b0) stale_seen = 1'b1;
    end
    checks++;
    if (stale_seen) begin
      failures++;
      $display("[TB] FAIL midrst_stale got=result want=no result");
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midrst_in_ready got=%b want=1", in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
